// File: rtl/signal_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | signal_gen_pkg                                                       |
// | Shared waveform-mode encoding, default sample rate, frequency clamp. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package signal_gen_pkg;

    typedef enum logic [1:0] {
        WAVE_TRI    = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_SQUARE = 2'd2,
        WAVE_PULSE  = 2'd3
    } wave_mode_t;

    localparam int DEFAULT_FS_HZ = 32000;

    // Saturate a requested frequency just below Nyquist.
    function automatic logic [31:0] clamp_freq(input logic [31:0] freq, input logic [31:0] fs_hz);
        logic [31:0] w_max;
        w_max = (fs_hz >> 1) - 32'd1;
        return (freq > w_max) ? w_max : freq;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wave_shaper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wave_shaper                                                          |
// | Combinational table-index to waveform-sample mapping.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wave_shaper
    import signal_gen_pkg::*;
#(
    parameter int TABLE_ADDR_W = 7,
    parameter int SAMPLE_W     = 8
) (
    input  logic [TABLE_ADDR_W-1:0] idx,
    input  wave_mode_t              mode,
    input  logic [TABLE_ADDR_W-1:0] duty,
    output logic [SAMPLE_W-1:0]     wave
);

    localparam int                      c_K    = SAMPLE_W - TABLE_ADDR_W;
    localparam logic [TABLE_ADDR_W-1:0] c_HALF = {1'b1, {(TABLE_ADDR_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0]     c_MAX  = '1;

    // D - idx taken modulo D; only used on the falling half where it is exact.
    logic [TABLE_ADDR_W-1:0] w_neg;
    assign w_neg = -idx;

    always_comb begin
        wave = '0;
        case (mode)
            WAVE_TRI: begin
                if (idx < c_HALF)       wave = SAMPLE_W'(idx) << (c_K + 1);
                else if (idx == c_HALF) wave = c_MAX;
                else                    wave = SAMPLE_W'(w_neg) << (c_K + 1);
            end
            WAVE_SAW:    wave = SAMPLE_W'(idx) << c_K;
            WAVE_SQUARE: wave = (idx < c_HALF) ? c_MAX : '0;
            WAVE_PULSE:  wave = (idx < duty) ? c_MAX : '0;
            default:     wave = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/signal_generator_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | signal_generator_multi                                               |
// | Phase-accumulator oscillator with period-boundary settings, volume.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module signal_generator_multi
    import signal_gen_pkg::*;
#(
    parameter int FS_HZ        = DEFAULT_FS_HZ,
    parameter int FREQ_W       = 14,
    parameter int PHASE_W      = 16,
    parameter int TABLE_ADDR_W = 7,
    parameter int SAMPLE_W     = 8
) (
    input  logic                    CLK_32KHz,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    phaseSync,
    input  logic [FREQ_W-1:0]       inputFrequency,
    input  logic [1:0]              mode,
    input  logic [TABLE_ADDR_W-1:0] duty,
    input  logic [7:0]              volume,
    output logic [SAMPLE_W-1:0]     outputSample,
    output logic                    sampleValid,
    output logic                    indexZero
);

    localparam logic [PHASE_W-1:0] c_FS   = PHASE_W'(FS_HZ);
    localparam logic [PHASE_W-1:0] c_STEP = PHASE_W'(FS_HZ >> TABLE_ADDR_W);
    localparam logic [31:0]        c_FS32 = 32'(FS_HZ);

    logic [PHASE_W-1:0]      r_phase;
    logic [FREQ_W-1:0]       r_freq_sh;
    wave_mode_t              r_mode_sh;
    logic [TABLE_ADDR_W-1:0] r_duty_sh;
    logic                    r_load_pending;

    logic [FREQ_W-1:0]       w_f_live;
    logic [FREQ_W-1:0]       w_f_eff;
    wave_mode_t              w_mode_live;
    wave_mode_t              w_mode_eff;
    logic [TABLE_ADDR_W-1:0] w_duty_eff;
    logic [PHASE_W-1:0]      w_sum;
    logic                    w_wrap;
    logic [TABLE_ADDR_W-1:0] w_idx;
    logic [SAMPLE_W-1:0]     w_wave;
    logic [8:0]              w_gain;
    logic [SAMPLE_W+8:0]     w_prod;
    logic [SAMPLE_W-1:0]     w_scaled;

    assign w_f_live    = FREQ_W'(clamp_freq(32'(inputFrequency), c_FS32));
    assign w_mode_live = wave_mode_t'(mode);
    assign w_f_eff     = r_load_pending ? w_f_live    : r_freq_sh;
    assign w_mode_eff  = r_load_pending ? w_mode_live : r_mode_sh;
    assign w_duty_eff  = r_load_pending ? duty        : r_duty_sh;

    // PHASE_W is sized so phase + fEff never overflows before the modulus test.
    assign w_sum  = r_phase + PHASE_W'(w_f_eff);
    assign w_wrap = (w_sum >= c_FS);
    assign w_idx  = TABLE_ADDR_W'(r_phase / c_STEP);

    wave_shaper #(
        .TABLE_ADDR_W (TABLE_ADDR_W),
        .SAMPLE_W     (SAMPLE_W)
    ) u_wave_shaper (
        .idx  (w_idx),
        .mode (w_mode_eff),
        .duty (w_duty_eff),
        .wave (w_wave)
    );

    assign w_gain   = {1'b0, volume} + 9'd1;
    assign w_prod   = (SAMPLE_W+9)'(w_wave) * (SAMPLE_W+9)'(w_gain);
    assign w_scaled = SAMPLE_W'(w_prod >> 8);

    always_ff @(posedge CLK_32KHz or posedge reset) begin
        if (reset) begin
            r_phase        <= '0;
            r_freq_sh      <= '0;
            r_mode_sh      <= WAVE_TRI;
            r_duty_sh      <= '0;
            r_load_pending <= 1'b1;
            outputSample   <= '0;
            sampleValid    <= 1'b0;
            indexZero      <= 1'b0;
        end else begin
            // The wrapping step still uses the old settings; new ones apply afterwards.
            if (!enable || phaseSync || r_load_pending || w_wrap) begin
                r_freq_sh <= w_f_live;
                r_mode_sh <= w_mode_live;
                r_duty_sh <= duty;
            end
            if (enable) begin
                r_load_pending <= 1'b0;
                if (phaseSync)   r_phase <= '0;
                else if (w_wrap) r_phase <= w_sum - c_FS;
                else             r_phase <= w_sum;
                outputSample <= w_scaled;
                indexZero    <= (w_idx == '0);
                sampleValid  <= 1'b1;
            end else begin
                outputSample <= '0;
                indexZero    <= 1'b0;
                sampleValid  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
